thread_sequencer: RTL and testbench
===================================

# thread_sequencer

Control sequencer sitting directly upstream of a thread processor in each core. It accepts 8-bit ALU micro-instructions over a valid/ready handshake and buffers them in a small FIFO. It expands each instruction into the cycle-by-cycle strobes the thread processor pipeline consumes:
- `read_id`
- `en_a`
- `en_b`
- `alu_op`
- `en_alu_out`
- `en_write`
- `write_id`

Four instances per core, one per thread.

## Interface
- `DEPTH`, 4: instruction FIFO entries (power of two, ≥2)
- `CNT_W`, 8: width of retired-instruction counter

- `clk`  in  1  clock line
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_instr`  in  8  {alu_op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}
- `in_ready`  out  1  FIFO can accept (`!full`)
- `read_id`  out  2  register-file read select
- `en_a`  out  1  load ALU A from RF_EX
- `en_b`  out  1  load ALU B from RF_EX
- `alu_op`  out  2  ALU opcode
- `en_alu_out`  out  1  ALU result capture into EX_WB
- `en_write`  out  1  register-file write enable
- `write_id`  out  2  register-file write select
- `retire`  out  1  one-cycle pulse in WB
- `retired_cnt`  out  CNT_W  instructions retired, wraps
- `busy`  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- **FIFO:** push on `in_valid && in_ready`. `in_ready` = !full. A push while full is refused even if a pop occurs in the same cycle. Pop only by the FSM. Entries are popped in order.
- **Current-instruction register:** `cur` is loaded on pop.
- **FSM states:** IDLE, RD_A, RD_B, LD_B, EXEC, WB. All outputs are Moore, decoded from state and `cur`. Every output not listed for a state is 0.
  - IDLE: no strobes. If the FIFO is non-empty: pop, go to RD_A.
  - RD_A: `read_id`=`cur.rs1`. Go to RD_B.
  - RD_B: `read_id`=`cur.rs2`, `en_a`=1. Go to LD_B.
  - LD_B: `en_b`=1. Go to EXEC.
  - EXEC: `alu_op`=`cur.op`, `en_alu_out`=1. Go to WB.
  - WB: `en_write`=1, `write_id`=`cur.rd`, `retire`=1, `retired_cnt` += 1 at the edge.
    - If the FIFO is non-empty: pop, go to RD_A.
    - Otherwise go to IDLE.
- **`retired_cnt`:** wraps modulo 2^CNT_W; no saturation.
- **Reset (any time, including mid-instruction):**
  - state ← IDLE, FIFO emptied, `cur` ← 0, `retired_cnt` ← 0.
  - All outputs go to 0 immediately, except `in_ready`=1.
  - The in-flight instruction is discarded and no write is issued.

## Timing
- Reset value of every output is 0, except `in_ready`=1.
- **Instruction pushed into an idle, empty sequencer at edge E0:**
  - IDLE pop at E1.
  - RD_A during E1–E2, RD_B during E2–E3, LD_B during E3–E4, EXEC during E4–E5, WB during E5–E6.
  - The register file is written at E6.
- **Back-to-back throughput:** 5 cycles per instruction, with WB → RD_A directly.
- **Alignment with the thread processor pipeline:**
  - RF_EX captures `rf[rs1]` at the end of RD_A.
  - `alu_a` captures it at the end of RD_B.
  - `alu_b` captures `rf[rs2]` at the end of LD_B.
  - EX_WB is valid after EXEC.
  - The write lands at the end of WB.
- **Read-after-write:** a following instruction's RD_A reads after the previous write, so there is no hazard in base mode.

## Configuration
- **`SEQ_OVERLAP_EN` defined:**
  - In WB with the FIFO non-empty and `head.rs1` ≠ `cur.rd`:
    - `read_id` = `head.rs1` during WB (combinational from the FIFO head).
    - Pop, then go directly to RD_B, skipping RD_A.
    - Throughput is 4 cycles per instruction.
  - If `head.rs1` == `cur.rd` (stale-read hazard, since RF_EX would sample before the write): behave as base mode (→ RD_A).
  - `rs2` is never hazardous, because it is read after the write edge.
- **`SEQ_OVERLAP_EN` undefined:** `read_id`=0 in WB. Behaviour exactly as in Operation.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC with 3 entries queued.
  - Expect all strobes 0, `in_ready`=1, `busy`=0, `retired_cnt`=0 immediately.
  - Expect no `en_write` after release.
- **Single instruction:** push 0x9B (op=2, rd=1, rs1=2, rs2=3) at E0.
  - Expect `read_id`=2 during E1–E2, `read_id`=3 with `en_a` during E2–E3, `en_b` during E3–E4.
  - Expect `en_alu_out` with `alu_op`=2 during E4–E5, `en_write` with `write_id`=1 and `retire` during E5–E6.
- **FIFO full:** hold `in_valid` high with the sequencer busy.
  - Expect `in_ready`=0 after DEPTH=4 accepted plus one popped.
  - Expect no push during a simultaneous pop while full.
  - Expect order preserved across 5 instructions.
- **Back-to-back:** push 3 independent instructions.
  - Base mode: `retire` pulses 5 cycles apart.
  - `SEQ_OVERLAP_EN`: pulses 4 cycles apart, and `read_id` = next `rs1` during WB.
- **Hazard (`SEQ_OVERLAP_EN`):** push 0x10 (rd=1) then 0x04 (rs1=1).
  - Expect WB → RD_A (5-cycle spacing).
  - Expect `read_id`=0 during WB, then `read_id`=1 in RD_A.
- **Counter wrap:** retire 256 instructions with CNT_W=8.
  - Expect `retired_cnt` 255 → 0.
  - Expect `busy`=0 only after the final WB.

Source files
------------

// File: rtl/thread_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | thread_sequencer: FIFO-buffered ALU micro-instruction to pipeline strobes |
// | Optional WB/RD_A overlap via SEQ_OVERLAP_EN.              Revision: 1.0   |
// +--------------------------------------------------------------------------+
module thread_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_instr,
  output logic             in_ready,
  output logic [1:0]       read_id,
  output logic             en_a,
  output logic             en_b,
  output logic [1:0]       alu_op,
  output logic             en_alu_out,
  output logic             en_write,
  output logic [1:0]       write_id,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    LD_B = 3'd3,
    EXEC = 3'd4,
    WB   = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  cur;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        skip_rd_a;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign push  = in_valid && !full;
  assign pop   = !empty && ((state == IDLE) || (state == WB));

`ifdef SEQ_OVERLAP_EN
  // Next rs1 may be read during WB only if it is not the register being written.
  assign skip_rd_a = (state == WB) && !empty && (head[3:2] != cur[5:4]);
`else
  assign skip_rd_a = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cur   <= head;
            state <= RD_A;
          end
        end
        RD_A: state <= RD_B;
        RD_B: state <= LD_B;
        LD_B: state <= EXEC;
        EXEC: state <= WB;
        WB: begin
          retired_cnt <= retired_cnt + CNT_W'(1);
          if (pop) begin
            cur   <= head;
            state <= skip_rd_a ? RD_B : RD_A;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_id    = 2'b00;
    en_a       = 1'b0;
    en_b       = 1'b0;
    alu_op     = 2'b00;
    en_alu_out = 1'b0;
    en_write   = 1'b0;
    write_id   = 2'b00;
    retire     = 1'b0;
    case (state)
      RD_A: read_id = cur[3:2];
      RD_B: begin
        read_id = cur[1:0];
        en_a    = 1'b1;
      end
      LD_B: en_b = 1'b1;
      EXEC: begin
        alu_op     = cur[7:6];
        en_alu_out = 1'b1;
      end
      WB: begin
        en_write = 1'b1;
        write_id = cur[5:4];
        retire   = 1'b1;
        read_id  = skip_rd_a ? head[3:2] : 2'b00;
      end
      default: ;
    endcase
  end

  assign in_ready = !full;
  assign busy     = (state != IDLE) || !empty;

endmodule
`default_nettype wire

// File: tb/tb_thread_sequencer.sv
`default_nettype none
// Testbench for thread_sequencer: randomized stimulus against a phase-based
// instruction model (phase 1..5 = step of the current instruction, 0 = idle).
module tb_thread_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
`ifdef SEQ_OVERLAP_EN
  localparam int SPACING = 4;
`else
  localparam int SPACING = 5;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_instr = 8'h00;
  logic             in_ready;
  logic [1:0]       read_id;
  logic             en_a;
  logic             en_b;
  logic [1:0]       alu_op;
  logic             en_alu_out;
  logic             en_write;
  logic [1:0]       write_id;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             busy;

  thread_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .read_id(read_id), .en_a(en_a), .en_b(en_b),
    .alu_op(alu_op), .en_alu_out(en_alu_out), .en_write(en_write),
    .write_id(write_id), .retire(retire), .retired_cnt(retired_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {in_ready, read_id, en_a, en_b, alu_op, en_alu_out,
                     en_write, write_id, retire, busy, retired_cnt};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  int         phase = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] q[$];
  logic [7:0] m_cnt = 8'h00;

  function automatic logic [20:0] exp_bus();
    logic [1:0] rid = 2'b00, op = 2'b00, wid = 2'b00;
    logic ea = 0, eb = 0, eo = 0, ew = 0, ret = 0;
    case (phase)
      1: rid = cur[3:2];
      2: begin rid = cur[1:0]; ea = 1; end
      3: eb = 1;
      4: begin op = cur[7:6]; eo = 1; end
      5: begin
        ew = 1; wid = cur[5:4]; ret = 1;
`ifdef SEQ_OVERLAP_EN
        if (q.size() > 0 && q[0][3:2] != cur[5:4]) rid = q[0][3:2];
`endif
      end
      default: ;
    endcase
    return {q.size() < DEPTH, rid, ea, eb, op, eo, ew, wid, ret,
            (phase != 0) || (q.size() > 0), m_cnt};
  endfunction

  task automatic model_reset();
    phase = 0;
    q.delete();
    cur = 8'h00;
    m_cnt = 8'h00;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] ins);
    bit acc;
    bit pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = v && (q.size() < DEPTH);
    pop = (phase == 0 || phase == 5) && (q.size() > 0);
    if (phase == 5) m_cnt = m_cnt + 8'd1;
    if (pop) begin
      int np = 1;
`ifdef SEQ_OVERLAP_EN
      if (phase == 5 && q[0][3:2] != cur[5:4]) np = 2;
`endif
      cur = q.pop_front();
      phase = np;
    end else begin
      phase = (phase == 0 || phase == 5) ? 0 : phase + 1;
    end
    if (acc) q.push_back(ins);
  endtask

  task automatic clk_step(input logic v, input logic [7:0] ins);
    in_valid = v;
    in_instr = ins;
    @(posedge clk);
    model_edge(v, ins);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_power_on();
    for (int i = 0; i < 3; i++) begin
      clk_step(1'b0, 8'h00);
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL power_on cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 9; i++) begin
      clk_step(i == 0, 8'h9B);
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
    end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 40; i++) begin
      clk_step(i < 12, 8'($urandom));
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL fifo_full cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
      if ((i == 4 && in_ready !== 1'b0) || (i == 6 && in_ready !== 1'b1)) begin
        miscompares++;
        $display("FAIL fifo_full_ready step=%0d got=%b", i, in_ready);
      end
      if (i == 4 || i == 6) vectors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ins[3];
    int r[$];
    ins[0] = 8'($urandom);
    for (int k = 1; k < 3; k++) begin
      ins[k] = 8'($urandom);
      ins[k][3:2] = ins[k-1][5:4] + 2'd1;
    end
    for (int i = 0; i < 22; i++) begin
      clk_step(i < 3, (i < 3) ? ins[i] : 8'h00);
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
      if (retire === 1'b1) r.push_back(i);
    end
    if (r.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_retire_count got=%0d exp=3", r.size());
    end else if ((r[1] - r[0]) !== SPACING || (r[2] - r[1]) !== SPACING) begin
      miscompares++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", r[1] - r[0], r[2] - r[1], SPACING);
    end
    vectors++;
  endtask

  task automatic test_hazard();
    int r[$];
    for (int i = 0; i < 16; i++) begin
      clk_step(i < 2, (i == 0) ? 8'h10 : 8'h04);
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL hazard cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
      if (retire === 1'b1) begin
        r.push_back(i);
        if (r.size() == 1 && read_id !== 2'd0) begin
          miscompares++;
          $display("FAIL hazard_wb_read_id got=%0d exp=0", read_id);
        end
        if (r.size() == 1) vectors++;
      end
    end
    if (r.size() !== 2 || (r[1] - r[0]) !== 5) begin
      miscompares++;
      $display("FAIL hazard_spacing got=%0d retires exp 2 at spacing 5", r.size());
    end
    vectors++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      clk_step(i < 4, 8'($urandom));
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL reset_setup cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
    end
    rst_n = 1'b0;
    #1;
    if ({read_id, en_a, en_b, alu_op, en_alu_out, en_write, write_id, retire} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_strobes got=%h exp=0", {read_id, en_a, en_b, alu_op, en_alu_out, en_write, write_id, retire});
    end
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (retired_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_cnt got=%0d exp=0", retired_cnt);
    end
    vectors += 4;
    model_reset();
    clk_step(1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_step(1'b0, 8'h00);
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL reset_after cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
    end
  endtask

  task automatic test_counter_wrap();
    int pushed = 0;
    bit saw_wrap = 0;
    logic [7:0] prev = retired_cnt;
    for (int i = 0; i < 1400; i++) begin
      bit v = (pushed < 256);
      if (v && q.size() < DEPTH) pushed++;
      clk_step(v, 8'($urandom));
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL counter_wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
      if (prev == 8'd255 && retired_cnt == 8'd0) saw_wrap = 1;
      prev = retired_cnt;
    end
    if (saw_wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL counter_wrap_seen got=%b exp=1", saw_wrap);
    end
    vectors++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      clk_step($urandom_range(0, 9) < 6, 8'($urandom));
      if (obs !== exp_bus()) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_bus());
      end
      vectors++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_power_on();
    test_single();
    test_fifo_full();
    test_back_to_back();
    test_hazard();
    test_reset();
    test_counter_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
